// File: rtl/amp_settle_detector.sv
// Waits for the op-amp square_out samples to settle, averages 2^AVG_LOG2 settled
// samples and publishes one amplitude word; flags sweeps that never settle.
module amp_settle_detector #(
  parameter int DATA_W     = 32,
  parameter int TOL        = 64,
  parameter int SETTLE_CNT = 16,
  parameter int AVG_LOG2   = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] settled_value,
  output logic              settled,
  output logic              timeout,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_STABLE = 2'd1,
    AVERAGE     = 2'd2,
    DONE        = 2'd3
  } state_t;

  localparam int SC_W  = $clog2(SETTLE_CNT + 1);
  localparam int AC_W  = AVG_LOG2 + 1;
  localparam int TC_W  = $clog2(TIMEOUT + 1);
  localparam int ACC_W = DATA_W + AVG_LOG2;

  localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE_CNT - 1);
  localparam logic [AC_W-1:0]   AVG_LAST    = AC_W'((1 << AVG_LOG2) - 1);
  localparam logic [TC_W-1:0]   TIMEOUT_VAL = TC_W'(TIMEOUT);
  localparam logic [DATA_W:0]   TOL_VAL     = (DATA_W + 1)'(TOL);

  state_t              state;
  state_t              next_state;
  logic                tick_d;
  logic                tick;
  logic [DATA_W-1:0]   prev;
  logic [DATA_W:0]     delta;
  logic                stable;
  logic [SC_W-1:0]     stable_cnt;
  logic [AC_W-1:0]     avg_cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [TC_W-1:0]     tick_cnt;

  assign tick    = sample_tick & ~tick_d;
  assign acc_sum = acc + ACC_W'(sample_in);

  always_comb begin
    delta = '0;
    if (sample_in >= prev) begin
      delta = {1'b0, sample_in} - {1'b0, prev};
    end else begin
      delta = {1'b0, prev} - {1'b0, sample_in};
    end
  end

  assign stable = (delta <= TOL_VAL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (tick) begin
      case (state)
        IDLE:        next_state = WAIT_STABLE;
        WAIT_STABLE: if (stable && stable_cnt == SETTLE_LAST) next_state = AVERAGE;
        AVERAGE: begin
          if (!stable) begin
            next_state = WAIT_STABLE;
          end else if (avg_cnt == AVG_LAST) begin
            next_state = DONE;
          end
        end
        DONE:        if (!stable) next_state = WAIT_STABLE;
        default:     next_state = IDLE;
      endcase
    end
  end

  // settled mirrors DONE: it rises on publish and drops on the first unstable tick
  always_comb begin
    settled   = (state == DONE);
    state_dbg = state;
  end

  // tick_d resets high so a sample_tick already asserted at reset release is not an edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_d        <= 1'b1;
      prev          <= '0;
      stable_cnt    <= '0;
      avg_cnt       <= '0;
      acc           <= '0;
      settled_value <= '0;
      tick_cnt      <= '0;
      timeout       <= 1'b0;
    end else begin
      tick_d <= sample_tick;
      if (tick) begin
        prev <= sample_in;
        case (state)
          WAIT_STABLE: begin
            stable_cnt <= stable ? stable_cnt + SC_W'(1) : '0;
            acc        <= '0;
            avg_cnt    <= '0;
          end
          AVERAGE: begin
            if (!stable) begin
              stable_cnt <= '0;
              acc        <= '0;
              avg_cnt    <= '0;
            end else begin
              acc     <= acc_sum;
              avg_cnt <= avg_cnt + AC_W'(1);
              if (avg_cnt == AVG_LAST) begin
                settled_value <= acc_sum[ACC_W-1:AVG_LOG2];
              end
            end
          end
          DONE: begin
            if (!stable) stable_cnt <= '0;
          end
          default: ;
        endcase

        // reaching DONE on the terminal-count tick suppresses the timeout
        if (state == WAIT_STABLE || state == AVERAGE) begin
          if (next_state == DONE) begin
            tick_cnt <= '0;
          end else if (tick_cnt != TIMEOUT_VAL) begin
            tick_cnt <= tick_cnt + TC_W'(1);
            if (tick_cnt + TC_W'(1) == TIMEOUT_VAL) timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_amp_settle_detector.sv
// Self-checking bench for amp_settle_detector: table-driven settle vectors plus
// hand-written timeout, step, reset-while-high and slow-tick sequences.
module tb_amp_settle_detector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [31:0] sample_in = '0;
  logic [31:0] settled_value;
  logic        settled;
  logic        timeout;
  logic [1:0]  state_dbg;

  typedef struct {
    string       name;
    logic        settled;
    logic [31:0] value;
    logic        timeout;
    logic [1:0]  state;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [31:0] alt;
    int          n_ticks;
    logic [1:0]  pre_state;
    logic        exp_settled;
    logic [31:0] exp_value;
    logic [1:0]  exp_state;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_errors = 0;

  amp_settle_detector dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .sample_in    (sample_in),
    .settled_value(settled_value),
    .settled      (settled),
    .timeout      (timeout),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic void expectOut(string name, logic s, logic [31:0] v, logic t, logic [1:0] st);
    exp_t e;
    e.name    = name;
    e.settled = s;
    e.value   = v;
    e.timeout = t;
    e.state   = st;
    exp_q.push_back(e);
  endfunction

  task automatic checkOutput();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (settled !== e.settled) begin
        n_errors++;
        $display("[TB] FAIL %s settled: got %b expected %b", e.name, settled, e.settled);
      end
      n_checks++;
      if (settled_value !== e.value) begin
        n_errors++;
        $display("[TB] FAIL %s settled_value: got %0d expected %0d", e.name, settled_value, e.value);
      end
      n_checks++;
      if (timeout !== e.timeout) begin
        n_errors++;
        $display("[TB] FAIL %s timeout: got %b expected %b", e.name, timeout, e.timeout);
      end
      n_checks++;
      if (state_dbg !== e.state) begin
        n_errors++;
        $display("[TB] FAIL %s state_dbg: got %0d expected %0d", e.name, state_dbg, e.state);
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n     = 1'b0;
    sample_tick = 1'b0;
    sample_in   = '0;
    @(posedge clk);
    #1;
    expectOut("reset", 1'b0, 32'd0, 1'b0, 2'd0);
    checkOutput();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One sample_tick pulse: high for hi clks, low for lo clks; outputs checked 1 clk after the rise
  task automatic applyStimulus(input logic [31:0] s, input int hi, input int lo, input bit glitch);
    @(negedge clk);
    sample_in   = s;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    checkOutput();
    for (int k = 1; k < hi; k++) begin
      @(negedge clk);
      if (glitch) sample_in = $urandom;
    end
    @(negedge clk);
    sample_tick = 1'b0;
    if (glitch) sample_in = $urandom;
    for (int k = 1; k < lo; k++) begin
      @(negedge clk);
      if (glitch) sample_in = $urandom;
    end
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"const_1000",  32'd1000, 32'd1000, 33, 2'd2, 1'b1, 32'd1000, 2'd3};
    vecs[1] = '{"alt_d40",     32'd1000, 32'd1040, 33, 2'd2, 1'b1, 32'd1020, 2'd3};
    vecs[2] = '{"alt_d64",     32'd1000, 32'd1064, 33, 2'd2, 1'b1, 32'd1032, 2'd3};
    vecs[3] = '{"alt_d65",     32'd1000, 32'd1065, 40, 2'd1, 1'b0, 32'd0,    2'd1};
    vecs[4] = '{"alt_0_64",    32'd0,    32'd64,   33, 2'd2, 1'b1, 32'd32,   2'd3};
    vecs[5] = '{"const_max",   32'hFFFF_FFF0, 32'hFFFF_FFF0, 33, 2'd2, 1'b1, 32'hFFFF_FFF0, 2'd3};
    vecs[6] = '{"const_zero",  32'd0,    32'd0,    33, 2'd2, 1'b1, 32'd0,    2'd3};

    for (int v = 0; v < 7; v++) begin
      doReset();
      for (int i = 1; i <= vecs[v].n_ticks; i++) begin
        if (i == vecs[v].n_ticks - 1)
          expectOut({vecs[v].name, "_pre"}, 1'b0, 32'd0, 1'b0, vecs[v].pre_state);
        if (i == vecs[v].n_ticks)
          expectOut(vecs[v].name, vecs[v].exp_settled, vecs[v].exp_value, 1'b0, vecs[v].exp_state);
        applyStimulus((i % 2 == 1) ? vecs[v].base : vecs[v].alt, 1, 1, 1'b0);
      end
    end

    // ramp never settles; timeout fires on tick 1001, stays sticky, FSM still settles afterwards
    doReset();
    for (int i = 1; i <= 1001; i++) begin
      if (i == 1)    expectOut("ramp_first", 1'b0, 32'd0, 1'b0, 2'd1);
      if (i == 1000) expectOut("ramp_t1000", 1'b0, 32'd0, 1'b0, 2'd1);
      if (i == 1001) expectOut("ramp_t1001", 1'b0, 32'd0, 1'b1, 2'd1);
      applyStimulus(32'(100 * i), 1, 1, 1'b0);
    end
    for (int i = 1002; i <= 1034; i++) begin
      if (i == 1033) expectOut("post_to_avg",  1'b0, 32'd0,    1'b1, 2'd2);
      if (i == 1034) expectOut("post_to_done", 1'b1, 32'd5000, 1'b1, 2'd3);
      applyStimulus(32'd5000, 1, 1, 1'b0);
    end
    doReset();

    // settle at 1000, small wobble stays DONE, then step to 5000 and re-settle
    for (int i = 1; i <= 33; i++) begin
      if (i == 33) expectOut("step_settle", 1'b1, 32'd1000, 1'b0, 2'd3);
      applyStimulus(32'd1000, 1, 1, 1'b0);
    end
    expectOut("done_wobble1", 1'b1, 32'd1000, 1'b0, 2'd3);
    applyStimulus(32'd1030, 1, 1, 1'b0);
    expectOut("done_wobble2", 1'b1, 32'd1000, 1'b0, 2'd3);
    applyStimulus(32'd1000, 1, 1, 1'b0);
    expectOut("step_drop", 1'b0, 32'd1000, 1'b0, 2'd1);
    applyStimulus(32'd5000, 1, 1, 1'b0);
    for (int i = 37; i <= 68; i++) begin
      if (i == 67) expectOut("step_pre", 1'b0, 32'd1000, 1'b0, 2'd2);
      if (i == 68) expectOut("step_resettle", 1'b1, 32'd5000, 1'b0, 2'd3);
      applyStimulus(32'd5000, 1, 1, 1'b0);
    end

    // reset in AVERAGE with sample_tick held high: no tick until a fresh rising edge
    doReset();
    for (int i = 1; i <= 33; i++) applyStimulus(32'd1000, 1, 1, 1'b0);
    for (int i = 34; i <= 53; i++) begin
      if (i == 53) expectOut("pre_reset_avg", 1'b0, 32'd1000, 1'b0, 2'd2);
      applyStimulus(32'd5000, 1, 1, 1'b0);
    end
    @(negedge clk);
    sample_tick = 1'b1;
    reset_n     = 1'b0;
    @(posedge clk);
    #1;
    expectOut("reset_high_tick", 1'b0, 32'd0, 1'b0, 2'd0);
    checkOutput();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expectOut("held_high_no_tick", 1'b0, 32'd0, 1'b0, 2'd0);
    checkOutput();
    @(negedge clk);
    sample_tick = 1'b0;
    expectOut("first_tick_after", 1'b0, 32'd0, 1'b0, 2'd1);
    applyStimulus(32'd1000, 1, 1, 1'b0);

    // slow ticks (1000 clk period) with sample_in glitching between ticks
    doReset();
    for (int i = 1; i <= 33; i++) begin
      if (i == 32) expectOut("slow_pre", 1'b0, 32'd0, 1'b0, 2'd2);
      if (i == 33) expectOut("slow_settle", 1'b1, 32'd1000, 1'b0, 2'd3);
      applyStimulus(32'd1000, 500, 500, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
